// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM states,
// register-write source encodings and the decoded control word.
package seq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    localparam logic [2:0] SRC_ALU = 3'b000;
    localparam logic [2:0] SRC_MEM = 3'b001;
    localparam logic [2:0] SRC_ACM = 3'b010;
    localparam logic [2:0] SRC_LDM = 3'b011;
    localparam logic [2:0] SRC_STM = 3'b100;

    // Short-format opcodes live in IR[IW-2:IW-5]
    localparam logic [3:0] kLDR = 4'd0;
    localparam logic [3:0] kLDM = 4'd1;
    localparam logic [3:0] kSTM = 4'd2;
    localparam logic [3:0] kACM = 4'd3;
    localparam logic [3:0] kRXR = 4'd4;
    localparam logic [3:0] kSUB = 4'd5;
    localparam logic [3:0] kADD = 4'd6;
    localparam logic [3:0] kAND = 4'd7;
    localparam logic [3:0] kXOR = 4'd8;
    localparam logic [3:0] kCMP = 4'd9;
    localparam logic [3:0] kCLR = 4'd10;
    localparam logic [3:0] kLSL = 4'd11;
    localparam logic [3:0] kSTR = 4'd12;
    localparam logic [3:0] kBEQ = 4'd13;
    localparam logic [3:0] kBNE = 4'd14;
    localparam logic [3:0] kDUN = 4'd15;

    // Long-format selector in IR[IW-2]
    localparam logic kLDA = 1'b0;
    localparam logic kSTA = 1'b1;

    typedef struct packed {
        logic [2:0] src;
        logic       reg_wr;
        logic       mem_rd;
        logic       mem_wr;
        logic       branch;
        logic       branch_ne;
        logic       halt;
        logic       alu_from_reg;
    } ctrl_word_t;

    function automatic logic is_mem_op(input ctrl_word_t cw);
        return cw.mem_rd | cw.mem_wr;
    endfunction

endpackage

// File: rtl/seq_ctrl_decode.sv
// Combinational opcode decoder: top five instruction bits to control word.
module ctrl_decode
    import seq_ctrl_pkg::*;
(
    input  logic [4:0]  op_hi,
    output ctrl_word_t  cw
);

    // Map the instruction's format/opcode bits onto the control word
    always_comb begin
        cw              = '0;
        cw.alu_from_reg = 1'b1;
        if (op_hi[4]) begin
            if (op_hi[3] == kSTA) begin
                cw.mem_wr = 1'b1;
            end else begin
                cw.mem_rd = 1'b1;
                cw.reg_wr = 1'b1;
                cw.src    = SRC_MEM;
            end
        end else begin
            case (op_hi[3:0])
                kLDR: begin
                    cw.mem_rd = 1'b1;
                    cw.reg_wr = 1'b1;
                    cw.src    = SRC_MEM;
                end
                kLDM: begin
                    cw.reg_wr = 1'b1;
                    cw.src    = SRC_LDM;
                end
                kSTM: begin
                    cw.reg_wr = 1'b1;
                    cw.src    = SRC_STM;
                end
                kACM, kRXR: begin
                    cw.reg_wr = 1'b1;
                    cw.src    = SRC_ACM;
                end
                kSUB, kADD, kAND, kXOR, kCMP, kCLR: cw.reg_wr = 1'b1;
                kLSL: begin
                    cw.reg_wr       = 1'b1;
                    cw.alu_from_reg = 1'b0;
                end
                kSTR: cw.mem_wr = 1'b1;
                kBEQ: cw.branch = 1'b1;
                kBNE: begin
                    cw.branch    = 1'b1;
                    cw.branch_ne = 1'b1;
                end
                kDUN:    cw.halt = 1'b1;
                default: cw.halt = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch/decode/exec/mem/writeback FSM with
// memory timeout, halt handshake and a saturating retired-instruction counter.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int IW      = 9,
    parameter int CNT_W   = 16,
    parameter int MEM_TMO = 15
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             InstrValid,
    input  logic [IW-1:0]    Instruction,
    input  logic             Zero,
    input  logic             MemAck,
    output logic             InstrReq,
    output logic             PcEn,
    output logic             PcBranch,
    output logic             RegWrEn,
    output logic             MemRdReq,
    output logic             MemWrReq,
    output logic             ALUFromReg,
    output logic             Ack,
    output logic             Err,
    output logic [2:0]       RegWrSource,
    output logic [CNT_W-1:0] Retired
);

    localparam int WAIT_W = (MEM_TMO < 2) ? 1 : $clog2(MEM_TMO);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [IW-1:0]     ir_q, ir_d;
    ctrl_word_t        cw_q, cw_d, cw_dec_s;
    logic              taken_q, taken_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic instr_req_q, pc_en_q, pc_branch_q, reg_wr_q, mem_rd_q, mem_wr_q;
    logic alu_q, ack_q, err_q;
    logic instr_req_d, pc_en_d, pc_branch_d, reg_wr_d, mem_rd_d, mem_wr_d;
    logic alu_d, ack_d, err_d;
    logic [2:0] src_q, src_d;

    // Decoding the incoming IR value lets the control word be valid in DECODE
    ctrl_decode u_decode (
        .op_hi (ir_d[IW-1:IW-5]),
        .cw    (cw_dec_s)
    );

    // Next-state, instruction register, branch and timeout bookkeeping
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        cw_d    = cw_q;
        taken_d = taken_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE:   state_d = Start ? S_FETCH : S_IDLE;
            S_FETCH: begin
                if (InstrValid) begin
                    ir_d    = Instruction;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
                cw_d    = cw_dec_s;
                taken_d = 1'b0;
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                taken_d = cw_q.branch & (cw_q.branch_ne ? ~Zero : Zero);
                wait_d  = '0;
                if (cw_q.halt) begin
                    state_d = S_HALT;
                end else if (is_mem_op(cw_q)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (MemAck) begin
                    state_d = S_WB;
                    wait_d  = '0;
                end else if (wait_q == WAIT_W'(MEM_TMO - 1)) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = Start ? S_FETCH : S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    // Retirement is counted on entry to WB or HALT, saturating at all-ones
    always_comb begin
        if ((state_d != state_q) && ((state_d == S_WB) || (state_d == S_HALT))
            && (retired_q != CNT_MAX)) begin
            retired_d = retired_q + CNT_W'(1);
        end else begin
            retired_d = retired_q;
        end
    end

    // Outputs are a function of the upcoming state so they register in step with it
    always_comb begin
        instr_req_d = 1'b0;
        pc_en_d     = 1'b0;
        pc_branch_d = 1'b0;
        reg_wr_d    = 1'b0;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        alu_d       = 1'b0;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        src_d       = SRC_ALU;
        case (state_d)
            S_FETCH:  instr_req_d = 1'b1;
            S_DECODE: src_d = cw_d.src;
            S_EXEC: begin
                src_d = cw_d.src;
                alu_d = cw_d.alu_from_reg;
            end
            S_MEM: begin
                src_d    = cw_d.src;
                mem_rd_d = cw_d.mem_rd;
                mem_wr_d = cw_d.mem_wr;
            end
            S_WB: begin
                src_d       = cw_d.src;
                reg_wr_d    = cw_d.reg_wr;
                pc_en_d     = 1'b1;
                pc_branch_d = taken_d;
            end
            S_HALT:  ack_d = 1'b1;
            S_ERR:   err_d = 1'b1;
            default: src_d = SRC_ALU;
        endcase
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= S_IDLE;
            ir_q        <= '0;
            cw_q        <= '0;
            taken_q     <= 1'b0;
            wait_q      <= '0;
            retired_q   <= '0;
            instr_req_q <= 1'b0;
            pc_en_q     <= 1'b0;
            pc_branch_q <= 1'b0;
            reg_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            alu_q       <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            src_q       <= SRC_ALU;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            cw_q        <= cw_d;
            taken_q     <= taken_d;
            wait_q      <= wait_d;
            retired_q   <= retired_d;
            instr_req_q <= instr_req_d;
            pc_en_q     <= pc_en_d;
            pc_branch_q <= pc_branch_d;
            reg_wr_q    <= reg_wr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            alu_q       <= alu_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            src_q       <= src_d;
        end
    end

    assign InstrReq    = instr_req_q;
    assign PcEn        = pc_en_q;
    assign PcBranch    = pc_branch_q;
    assign RegWrEn     = reg_wr_q;
    assign MemRdReq    = mem_rd_q;
    assign MemWrReq    = mem_wr_q;
    assign ALUFromReg  = alu_q;
    assign Ack         = ack_q;
    assign Err         = err_q;
    assign RegWrSource = src_q;
    assign Retired     = retired_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Self-checking bench for seq_ctrl: directed scenarios plus randomized
// instruction streams checked against a mnemonic-level reference model.
module tb_seq_ctrl;
    import seq_ctrl_pkg::*;

    typedef enum int {
        M_LDR, M_LDM, M_STM, M_ACM, M_RXR, M_SUB, M_ADD, M_AND, M_XOR,
        M_CMP, M_CLR, M_LSL, M_STR, M_BEQ, M_BNE, M_DUN, M_LDA, M_STA
    } mn_e;

    typedef struct {
        logic [2:0] src;
        bit wr, rd, wm, alu, beq, bne, dun;
    } exp_t;

    logic Clk, Reset_n, Start, InstrValid, Zero, MemAck;
    logic [8:0] Instruction;
    logic InstrReq, PcEn, PcBranch, RegWrEn, MemRdReq, MemWrReq, ALUFromReg, Ack, Err;
    logic [2:0] RegWrSource;
    logic [15:0] Retired;
    logic s_req, s_pcen, s_pcbr, s_rwe, s_mrd, s_mwr, s_alu, s_ack, s_err;
    logic [2:0] s_src;
    logic [3:0] s_retired;

    int checks = 0;
    int errors = 0;
    int retired_cnt = 0;
    logic [3:0] op_tab [16] = '{kLDR, kLDM, kSTM, kACM, kRXR, kSUB, kADD, kAND,
                               kXOR, kCMP, kCLR, kLSL, kSTR, kBEQ, kBNE, kDUN};

    seq_ctrl #(.IW(9), .CNT_W(16), .MEM_TMO(15)) u_dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .InstrValid(InstrValid),
        .Instruction(Instruction), .Zero(Zero), .MemAck(MemAck),
        .InstrReq(InstrReq), .PcEn(PcEn), .PcBranch(PcBranch), .RegWrEn(RegWrEn),
        .MemRdReq(MemRdReq), .MemWrReq(MemWrReq), .ALUFromReg(ALUFromReg),
        .Ack(Ack), .Err(Err), .RegWrSource(RegWrSource), .Retired(Retired)
    );

    seq_ctrl #(.IW(9), .CNT_W(4), .MEM_TMO(15)) u_small (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .InstrValid(InstrValid),
        .Instruction(Instruction), .Zero(Zero), .MemAck(MemAck),
        .InstrReq(s_req), .PcEn(s_pcen), .PcBranch(s_pcbr), .RegWrEn(s_rwe),
        .MemRdReq(s_mrd), .MemWrReq(s_mwr), .ALUFromReg(s_alu),
        .Ack(s_ack), .Err(s_err), .RegWrSource(s_src), .Retired(s_retired)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference model: behaviour of each mnemonic at instruction level
    function automatic exp_t info(input mn_e m);
        exp_t e;
        e.rd  = m inside {M_LDR, M_LDA};
        e.wm  = m inside {M_STR, M_STA};
        e.beq = (m == M_BEQ);
        e.bne = (m == M_BNE);
        e.dun = (m == M_DUN);
        e.wr  = !(e.wm || e.beq || e.bne || e.dun);
        e.alu = (m != M_LSL);
        if (e.rd)                       e.src = 3'b001;
        else if (m == M_LDM)            e.src = 3'b011;
        else if (m == M_STM)            e.src = 3'b100;
        else if (m inside {M_ACM, M_RXR}) e.src = 3'b010;
        else                            e.src = 3'b000;
        return e;
    endfunction

    function automatic logic [8:0] encode(input mn_e m);
        logic [8:0] r;
        r = 9'($urandom);
        if (m == M_LDA) begin
            r[8] = 1'b1; r[7] = kLDA;
        end else if (m == M_STA) begin
            r[8] = 1'b1; r[7] = kSTA;
        end else begin
            r[8] = 1'b0; r[7:4] = op_tab[int'(m)];
        end
        return r;
    endfunction

    function automatic int sat(input int n, input int mx);
        return (n > mx) ? mx : n;
    endfunction

    // Fetch (with wait cycles), decode and exec; ends at posedge+1 of the cycle after EXEC
    task automatic front(input mn_e m, input int fdly, input bit zero);
        exp_t e;
        e = info(m);
        chk("fetch_req", {31'd0, InstrReq}, 32'd1);
        repeat (fdly) begin
            InstrValid = 1'b0; Instruction = 9'($urandom);
            tick();
            chk("fetch_wait", {31'd0, InstrReq}, 32'd1);
        end
        InstrValid = 1'b1; Instruction = encode(m);
        tick();
        InstrValid = 1'($urandom); Instruction = 9'($urandom);
        Zero = ~zero; Start = 1'($urandom); MemAck = 1'($urandom);
        chk("dec_src", {29'd0, RegWrSource}, {29'd0, e.src});
        chk("dec_req", {31'd0, InstrReq}, 32'd0);
        tick();
        Zero = zero;
        chk("exec_alu", {31'd0, ALUFromReg}, {31'd0, e.alu});
        chk("exec_src", {29'd0, RegWrSource}, {29'd0, e.src});
        tick();
        Zero = 1'($urandom); MemAck = 1'b0; Start = 1'b0; InstrValid = 1'b0;
    endtask

    task automatic chk_retired(input string tag);
        chk(tag, {16'd0, Retired}, 32'(sat(retired_cnt, 65535)));
        chk({tag, "_small"}, {28'd0, s_retired}, 32'(sat(retired_cnt, 15)));
    endtask

    task automatic run(input mn_e m, input int fdly, input int mlat, input bit zero);
        exp_t e;
        int nhigh;
        bit taken;
        e = info(m);
        front(m, fdly, zero);
        if (e.dun) begin
            retired_cnt++;
            chk("halt_ack", {31'd0, Ack}, 32'd1);
            chk_retired("halt_retired");
            repeat (2) begin
                tick();
                chk("halt_hold", {31'd0, Ack}, 32'd1);
            end
            chk_retired("halt_once");
            Start = 1'b1;
            tick();
            Start = 1'b0;
            chk("halt_exit_ack", {31'd0, Ack}, 32'd0);
            return;
        end
        if (e.rd || e.wm) begin
            nhigh = 0;
            for (int k = 1; k <= mlat; k++) begin
                if ((e.rd ? MemRdReq : MemWrReq) === 1'b1) nhigh++;
                chk("mem_other_req", {31'd0, (e.rd ? MemWrReq : MemRdReq)}, 32'd0);
                chk("mem_src", {29'd0, RegWrSource}, {29'd0, e.src});
                MemAck = (k == mlat); Start = 1'($urandom);
                tick();
                MemAck = 1'b0; Start = 1'b0;
            end
            chk("mem_req_cycles", 32'(nhigh), 32'(mlat));
        end
        retired_cnt++;
        taken = (e.beq && zero) || (e.bne && !zero);
        chk("wb_regwr", {31'd0, RegWrEn}, {31'd0, e.wr});
        chk("wb_src", {29'd0, RegWrSource}, {29'd0, e.src});
        chk("wb_pcen", {31'd0, PcEn}, 32'd1);
        chk("wb_pcbranch", {31'd0, PcBranch}, {31'd0, taken});
        chk("wb_memreq", {30'd0, MemRdReq, MemWrReq}, 32'd0);
        chk_retired("wb_retired");
        tick();
        chk("post_wb_pcen", {31'd0, PcEn}, 32'd0);
        chk("post_wb_src", {29'd0, RegWrSource}, 32'd0);
    endtask

    initial begin
        mn_e m;
        Reset_n = 1'b0; Start = 1'b0; InstrValid = 1'b0; Instruction = 9'd0;
        Zero = 1'b0; MemAck = 1'b0;
        tick(); tick();
        chk("rst_outputs", {20'd0, InstrReq, PcEn, PcBranch, RegWrEn, MemRdReq,
            MemWrReq, ALUFromReg, Ack, Err, RegWrSource}, 32'd0);
        chk_retired("rst_retired");
        #3 Reset_n = 1'b1;
        InstrValid = 1'b1; MemAck = 1'b1;
        tick(); tick();
        chk("idle_no_start", {31'd0, InstrReq}, 32'd0);
        InstrValid = 1'b0; MemAck = 1'b0;
        Start = 1'b1; tick(); Start = 1'b0;
        chk("start_fetch", {31'd0, InstrReq}, 32'd1);
        tick();
        #2 Reset_n = 1'b0;
        #1 chk("rst_mid_fetch", {31'd0, InstrReq}, 32'd0);
        #1 Reset_n = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, InstrReq}, 32'd0);
        Start = 1'b1; tick(); Start = 1'b0;

        run(M_ADD, 0, 0, 1'b0);
        run(M_LDR, 1, 4, 1'b0);
        run(M_STA, 0, 2, 1'b1);
        run(M_BEQ, 0, 0, 1'b1);
        run(M_BNE, 2, 0, 1'b1);
        run(M_BEQ, 0, 0, 1'b0);
        run(M_BNE, 0, 0, 1'b0);
        run(M_LSL, 1, 0, 1'b0);
        run(M_LDM, 0, 0, 1'b0);
        run(M_STM, 0, 0, 1'b1);
        run(M_ACM, 0, 0, 1'b0);
        run(M_DUN, 0, 0, 1'b0);
        for (int i = 0; i < 24; i++) begin
            m = mn_e'($urandom_range(0, 17));
            run(m, int'($urandom_range(0, 3)), int'($urandom_range(1, 15)), 1'($urandom));
        end
        run(M_STR, 0, 15, 1'b0);
        run(M_LDA, 0, 1, 1'b0);

        front(M_LDR, 0, 1'b0);
        chk("mem1_rdreq", {31'd0, MemRdReq}, 32'd1);
        tick();
        chk("mem2_rdreq", {31'd0, MemRdReq}, 32'd1);
        #2 Reset_n = 1'b0;
        #1 chk("rst_mid_mem", {29'd0, MemRdReq, MemWrReq, Err}, 32'd0);
        chk("rst_mid_mem_src", {29'd0, RegWrSource}, 32'd0);
        retired_cnt = 0;
        chk_retired("rst_mid_mem_retired");
        #1 Reset_n = 1'b1;
        tick();
        chk("post_mem_rst_idle", {31'd0, InstrReq}, 32'd0);
        Start = 1'b1; tick(); Start = 1'b0;

        front(M_STR, 1, 1'b0);
        for (int k = 1; k <= 15; k++) begin
            chk("tmo_wrreq", {31'd0, MemWrReq}, 32'd1);
            chk("tmo_no_err_yet", {31'd0, Err}, 32'd0);
            tick();
        end
        chk("tmo_err", {31'd0, Err}, 32'd1);
        chk("tmo_req_drop", {29'd0, MemRdReq, MemWrReq, InstrReq}, 32'd0);
        Start = 1'b1; InstrValid = 1'b1; MemAck = 1'b1;
        repeat (3) begin
            tick();
            chk("err_held", {31'd0, Err}, 32'd1);
            chk("err_ignores_start", {31'd0, InstrReq}, 32'd0);
        end
        chk_retired("err_retired");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
